csr_bank: RTL

- Parametrised successor to the single CSR register: a bank of Count machine-mode CSRs at consecutive 12-bit addresses from BaseAddr.
- Per-register write masks and reset values; full RISC-V Zicsr semantics, including the no-write rules and true clear.
- Free-running 64-bit cycle counter exposed as two 32-bit CSRs.
- Sits beside the decoder/execute stage. Reports hit/illegal per access so the trap logic can raise illegal-instruction.

---
 rtl/csr_bank.sv | 119 +++++++++++
 1 files changed

// File: rtl/csr_bank.sv
// Bank of Count machine-mode CSRs with Zicsr read/modify/write semantics and an optional
// read-only 64-bit cycle counter, included when CSR_BANK_CYCLE_EN is defined.
module csr_bank #(
    parameter int              Count      = 4,
    parameter logic [11:0]     BaseAddr   = 12'h340,
    parameter logic [Count*32-1:0] WriteMask  = {Count{32'hFFFF_FFFF}},
    parameter logic [Count*32-1:0] ResetValue = {Count{32'h0}},
    parameter logic [11:0]     CycleAddr  = 12'hB00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [11:0] addr_i,
    input  logic [2:0]  op_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] in_i,
    output logic [31:0] old_o,
    output logic        hit_o,
    output logic        illegal_o
);

    localparam logic [Count-1:0][31:0] Mask = WriteMask;
    localparam logic [Count-1:0][31:0] Init = ResetValue;

    logic [Count-1:0][31:0] regs_q, regs_d;
    logic [Count-1:0]       sel;
    logic                   reg_hit, cyc_hit, op_ok, wr_req, bank_hit;
    logic [31:0]            src, cur, nv, cyc_val;
    logic [31:0]            old_q, old_d;
    logic                   hit_q, hit_d, illegal_q, illegal_d;

    // rd only matters to the register file; writes happen even for rd==0.
    logic unused_rd;
    assign unused_rd = ^rd_i;

    always_comb begin
        sel = '0;
        cur = '0;
        for (int i = 0; i < Count; i++) begin
            if (addr_i == BaseAddr + 12'(i)) begin
                sel[i] = 1'b1;
                cur    = regs_q[i];
            end
        end
    end
    assign reg_hit = |sel;

`ifdef CSR_BANK_CYCLE_EN
    logic [63:0] cyc_q, cyc_d;
    logic        cyc_lo_sel, cyc_hi_sel;

    assign cyc_d      = cyc_q + 64'd1;
    assign cyc_lo_sel = (addr_i == CycleAddr);
    assign cyc_hi_sel = (addr_i == CycleAddr + 12'h080);
    // General registers win if the two address ranges were ever configured to overlap.
    assign cyc_hit    = (cyc_lo_sel | cyc_hi_sel) & ~reg_hit;
    assign cyc_val    = cyc_hi_sel ? cyc_q[63:32] : cyc_q[31:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) cyc_q <= '0;
        else         cyc_q <= cyc_d;
    end
`else
    logic unused_cyc;
    assign unused_cyc = (addr_i == CycleAddr);
    assign cyc_hit    = 1'b0;
    assign cyc_val    = '0;
`endif

    assign src = op_i[2] ? {27'b0, rs1_i} : in_i;

    always_comb begin
        op_ok = 1'b1;
        nv    = src;
        case (op_i[1:0])
            2'b01:   nv = src;
            2'b10:   nv = cur | src;
            2'b11:   nv = cur & ~src;
            default: op_ok = 1'b0;
        endcase
        // Set/clear with rs1==0 is a pure read; write forms always write.
        wr_req    = op_ok && (op_i[1:0] == 2'b01 || rs1_i != 5'd0);
        bank_hit  = op_ok && (reg_hit || cyc_hit);
        old_d     = !bank_hit ? 32'h0 : (reg_hit ? cur : cyc_val);
        hit_d     = bank_hit;
        illegal_d = !bank_hit || (cyc_hit && wr_req);
    end

    always_comb begin
        regs_d = regs_q;
        if (en_i && wr_req) begin
            for (int i = 0; i < Count; i++) begin
                if (sel[i]) regs_d[i] = (regs_q[i] & ~Mask[i]) | (nv & Mask[i]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q    <= Init;
            old_q     <= '0;
            hit_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            if (en_i) begin
                old_q     <= old_d;
                hit_q     <= hit_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign old_o     = old_q;
    assign hit_o     = hit_q;
    assign illegal_o = illegal_q;

endmodule
